// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution stage (sequencer, weight memories, MACs, window buffer).
// Latency: none, declarations only.
// Backpressure: not applicable.
package conv_pkg;

    localparam int NUM_TAPS  = 9;
    localparam int NUM_FILT  = 16;
    localparam int WT_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_WIN = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_OUT      = 3'd4
    } conv_seq_state_t;

endpackage

// File: rtl/conv_wt_seq_if.sv
// Control/handshake bundle between the weight sequencer and its neighbours (window buffer, MACs, downstream).
// Latency: none, wiring only.
// Backpressure: win_valid/win_ready upstream, acc_valid/acc_ready downstream.
interface conv_wt_seq_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 10
);
    import conv_pkg::*;

    logic              start;
    logic              abort;
    logic              win_valid;
    logic              win_ready;
    logic [ADDR_W-1:0] wt_addr;
    logic              mac_en;
    logic              mac_clr;
    logic              acc_valid;
    logic              acc_ready;
    logic [CNT_W-1:0]  win_cnt;
    logic              busy;
    logic              frame_done;

    // Sequencer side
    modport master (
        input  start, abort, win_valid, acc_ready,
        output win_ready, wt_addr, mac_en, mac_clr, acc_valid, win_cnt, busy, frame_done
    );

    // Environment side (window buffer, MAC array, downstream stage)
    modport slave (
        output start, abort, win_valid, acc_ready,
        input  win_ready, wt_addr, mac_en, mac_clr, acc_valid, win_cnt, busy, frame_done
    );

endinterface

// File: rtl/conv_strobe_dly.sv
// Delays the {issue, first-tap} flags by RD_LAT cycles to line MAC strobes up with memory read data.
// Latency: exactly RD_LAT cycles from i_issue/i_first to o_mac_en/o_mac_clr.
// Backpressure: none; i_flush clears every stage on the next edge.
module conv_strobe_dly #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_issue,
    input  logic i_first,
    output logic o_mac_en,
    output logic o_mac_clr
);
    import conv_pkg::*;

    logic [RD_LAT-1:0] r_issue_sr;
    logic [RD_LAT-1:0] r_first_sr;

    // Shift both flags one stage per cycle; a flush empties the whole pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_sr <= '0;
            r_first_sr <= '0;
        end else if (i_flush) begin
            r_issue_sr <= '0;
            r_first_sr <= '0;
        end else begin
            r_issue_sr[0] <= i_issue;
            r_first_sr[0] <= i_first;
            for (int i = 1; i < RD_LAT; i++) begin
                r_issue_sr[i] <= r_issue_sr[i-1];
                r_first_sr[i] <= r_first_sr[i-1];
            end
        end
    end

    // The tap counter idles at 0, so the first flag only means something alongside issue
    assign o_mac_en  = r_issue_sr[RD_LAT-1];
    assign o_mac_clr = r_issue_sr[RD_LAT-1] & r_first_sr[RD_LAT-1];

endmodule

// File: rtl/conv_wt_seq.sv
// Tap sequencer for the 3x3 conv stage: broadcasts tap addresses, times MAC strobes, steps window positions.
// Latency: NUM_TAPS+RD_LAT cycles from ISSUE entry to acc_valid; minimum window period NUM_TAPS+RD_LAT+2.
// Backpressure: waits in WAIT_WIN for win_valid; holds acc_valid in OUT until acc_ready.
module conv_wt_seq #(
    parameter int NUM_TAPS = conv_pkg::NUM_TAPS,
    parameter int ADDR_W   = conv_pkg::WT_ADDR_W,
    parameter int RD_LAT   = 1,
    parameter int NUM_WIN  = 676,
    parameter int CNT_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    conv_wt_seq_if.master bus
);
    import conv_pkg::*;

    localparam int                DR_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
    localparam logic [DR_W-1:0]   LAST_DR  = DR_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  LAST_WIN = CNT_W'(NUM_WIN - 1);

    conv_seq_state_t   r_state;
    conv_seq_state_t   w_state_nxt;
    logic [ADDR_W-1:0] r_tap;
    logic [DR_W-1:0]   r_drain;
    logic [CNT_W-1:0]  r_win_cnt;
    logic              r_frame_done;

    logic              w_last_tap;
    logic              w_drain_done;
    logic              w_acc_hs;
    logic              w_last_win;
    logic              w_win_ready;
    logic [ADDR_W-1:0] w_wt_addr;
    logic              w_acc_valid;
    logic              w_busy;
    logic              w_mac_en;
    logic              w_mac_clr;

    assign w_last_tap   = (r_state == ST_ISSUE) && (r_tap == LAST_TAP);
    assign w_drain_done = (r_state == ST_DRAIN) && (r_drain == LAST_DR);
    assign w_acc_hs     = (r_state == ST_OUT) && bus.acc_ready;
    assign w_last_win   = (r_win_cnt == LAST_WIN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: abort beats everything; win_valid is only looked at in WAIT_WIN
    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (bus.start)     w_state_nxt = ST_WAIT_WIN;
                ST_WAIT_WIN: if (bus.win_valid) w_state_nxt = ST_ISSUE;
                ST_ISSUE:    if (w_last_tap)    w_state_nxt = ST_DRAIN;
                ST_DRAIN:    if (w_drain_done)  w_state_nxt = ST_OUT;
                ST_OUT:      if (w_acc_hs)      w_state_nxt = w_last_win ? ST_IDLE : ST_WAIT_WIN;
                default:                        w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state and tap counter only
    always_comb begin
        w_win_ready = 1'b0;
        w_wt_addr   = '0;
        w_acc_valid = 1'b0;
        w_busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_ISSUE: begin
                w_wt_addr   = r_tap;
                w_win_ready = (r_tap == LAST_TAP);
            end
            ST_OUT:  w_acc_valid = 1'b1;
            default: ;
        endcase
    end

    // Tap counter: parked at 0 outside ISSUE so each window starts from tap 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_tap <= '0;
        else if (bus.abort || r_state != ST_ISSUE) r_tap <= '0;
        else if (r_tap == LAST_TAP)                r_tap <= '0;
        else                                       r_tap <= r_tap + 1'b1;
    end

    // DRAIN counter: covers the read latency of the last tap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_drain <= '0;
        else if (bus.abort || r_state != ST_DRAIN) r_drain <= '0;
        else if (r_drain == LAST_DR)               r_drain <= '0;
        else                                       r_drain <= r_drain + 1'b1;
    end

    // Window counter: cleared by start, bumped per accepted non-final window, held across abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
        end else if (!bus.abort) begin
            if (r_state == ST_IDLE && bus.start) r_win_cnt <= '0;
            else if (w_acc_hs && !w_last_win)    r_win_cnt <= r_win_cnt + 1'b1;
        end
    end

    // Frame-done pulse in the cycle after the last window is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_frame_done <= 1'b0;
        else        r_frame_done <= !bus.abort && w_acc_hs && w_last_win;
    end

    conv_strobe_dly #(
        .RD_LAT (RD_LAT)
    ) u_strobe_dly (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (bus.abort),
        .i_issue   (r_state == ST_ISSUE),
        .i_first   (r_tap == '0),
        .o_mac_en  (w_mac_en),
        .o_mac_clr (w_mac_clr)
    );

    assign bus.win_ready  = w_win_ready;
    assign bus.wt_addr    = w_wt_addr;
    assign bus.mac_en     = w_mac_en;
    assign bus.mac_clr    = w_mac_clr;
    assign bus.acc_valid  = w_acc_valid;
    assign bus.win_cnt    = r_win_cnt;
    assign bus.busy       = w_busy;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_wt_seq.sv
// Bench for conv_wt_seq: two instances (RD_LAT=1/NUM_WIN=3 and RD_LAT=2/NUM_WIN=1) share one input stream.
// A timestamp-based model predicts every output each cycle; directed phases pin it with literal expectations.
// Random phase exercises start/abort/win_valid/acc_ready interleavings including an async reset mid-run.
module tb_conv_wt_seq;

    localparam int NT = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, abort = 1'b0, win_valid = 1'b0, acc_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_wt_seq_if #(.ADDR_W(4), .CNT_W(2)) bus1 ();
    conv_wt_seq_if #(.ADDR_W(4), .CNT_W(2)) bus2 ();

    assign bus1.start = start;  assign bus1.abort = abort;
    assign bus1.win_valid = win_valid;  assign bus1.acc_ready = acc_ready;
    assign bus2.start = start;  assign bus2.abort = abort;
    assign bus2.win_valid = win_valid;  assign bus2.acc_ready = acc_ready;

    conv_wt_seq #(.NUM_TAPS(9), .ADDR_W(4), .RD_LAT(1), .NUM_WIN(3), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    conv_wt_seq #(.NUM_TAPS(9), .ADDR_W(4), .RD_LAT(2), .NUM_WIN(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [3:0] o_wt[2];
    logic [1:0] o_cnt[2];
    logic       o_wr[2], o_en[2], o_clr[2], o_av[2], o_busy[2], o_fd[2];

    assign o_wt[0] = bus1.wt_addr;     assign o_wt[1] = bus2.wt_addr;
    assign o_cnt[0] = bus1.win_cnt;    assign o_cnt[1] = bus2.win_cnt;
    assign o_wr[0] = bus1.win_ready;   assign o_wr[1] = bus2.win_ready;
    assign o_en[0] = bus1.mac_en;      assign o_en[1] = bus2.mac_en;
    assign o_clr[0] = bus1.mac_clr;    assign o_clr[1] = bus2.mac_clr;
    assign o_av[0] = bus1.acc_valid;   assign o_av[1] = bus2.acc_valid;
    assign o_busy[0] = bus1.busy;      assign o_busy[1] = bus2.busy;
    assign o_fd[0] = bus1.frame_done;  assign o_fd[1] = bus2.frame_done;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int nwin_of(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: busy flag, window count, the cycle its current window entered ISSUE (-1 = none).
    // All window-relative outputs follow from k = cycle - issue_start.
    typedef struct {
        int wt; bit wr; bit en; bit clr; bit av; bit busy; bit fd; int cnt;
    } exp_t;

    int cyc;
    bit m_busy[2];
    int m_cnt[2];
    int m_c[2];
    bit m_fd[2];

    function automatic exp_t expect_of(input int i);
        exp_t e;
        int   k;
        e.wt = 0; e.wr = 0; e.en = 0; e.clr = 0; e.av = 0;
        e.busy = m_busy[i]; e.fd = m_fd[i]; e.cnt = m_cnt[i];
        if (m_c[i] >= 0) begin
            k = cyc - m_c[i];
            if (k < NT) e.wt = k;
            e.wr  = (k == NT - 1);
            e.en  = (k >= lat_of(i)) && (k <= NT - 1 + lat_of(i));
            e.clr = (k == lat_of(i));
            e.av  = (k >= NT + lat_of(i));
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            cyc = 0;
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_cnt[i] = 0; m_c[i] = -1; m_fd[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = expect_of(i);
                m_fd[i] = 0;
                if (abort) begin
                    m_busy[i] = 0; m_c[i] = -1;
                end else if (!m_busy[i]) begin
                    if (start) begin m_busy[i] = 1; m_cnt[i] = 0; end
                end else if (m_c[i] < 0) begin
                    if (win_valid) m_c[i] = cyc + 1;
                end else if (e.av && acc_ready) begin
                    m_c[i] = -1;
                    if (m_cnt[i] == nwin_of(i) - 1) begin m_busy[i] = 0; m_fd[i] = 1; end
                    else m_cnt[i] = m_cnt[i] + 1;
                end
            end
            cyc = cyc + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                e = expect_of(i);
                chk($sformatf("dut%0d_wt_addr", i), o_wt[i], e.wt);
                chk($sformatf("dut%0d_win_ready", i), o_wr[i], e.wr);
                chk($sformatf("dut%0d_mac_en", i), o_en[i], e.en);
                chk($sformatf("dut%0d_mac_clr", i), o_clr[i], e.clr);
                chk($sformatf("dut%0d_acc_valid", i), o_av[i], e.av);
                chk($sformatf("dut%0d_busy", i), o_busy[i], e.busy);
                chk($sformatf("dut%0d_frame_done", i), o_fd[i], e.fd);
                chk($sformatf("dut%0d_win_cnt", i), o_cnt[i], e.cnt);
            end
        end
    end

    // ---------------- event counters for the frame test ----------------
    bit cnt_on = 0;
    int n_wr = 0, n_en = 0, n_clr = 0, n_fd = 0;
    int seen[$];

    always @(negedge clk) begin
        if (cnt_on) begin
            if (o_wr[0])  n_wr++;
            if (o_en[0])  n_en++;
            if (o_clr[0]) n_clr++;
            if (o_fd[0])  n_fd++;
            if (o_busy[0] && (seen.size() == 0 || seen[$] != int'(o_cnt[0])))
                seen.push_back(int'(o_cnt[0]));
        end
    end

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_dut%0d_wt_addr", tag, i), o_wt[i], 0);
            chk($sformatf("%s_dut%0d_win_ready", tag, i), o_wr[i], 0);
            chk($sformatf("%s_dut%0d_mac_en", tag, i), o_en[i], 0);
            chk($sformatf("%s_dut%0d_mac_clr", tag, i), o_clr[i], 0);
            chk($sformatf("%s_dut%0d_acc_valid", tag, i), o_av[i], 0);
            chk($sformatf("%s_dut%0d_win_cnt", tag, i), o_cnt[i], 0);
            chk($sformatf("%s_dut%0d_busy", tag, i), o_busy[i], 0);
            chk($sformatf("%s_dut%0d_frame_done", tag, i), o_fd[i], 0);
        end
    endtask

    // Waits (at negedges) for dut 'which' to show tap 'tap' in window 'wc'; bounded.
    task automatic wait_tap(input int which, input int tap, input int wc, input string nm);
        bit found = 0;
        for (int n = 0; n < 80 && !found; n++) begin
            @(negedge clk);
            if (o_busy[which] && o_wt[which] == tap[3:0] && o_cnt[which] == wc[1:0]) found = 1;
        end
        chk(nm, found, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        // Reset asserted with no clock edge yet: outputs must be 0 straight away
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_zero("post_reset");

        // Single window timing, start in cycle 0
        @(posedge clk); #1;
        start = 1; win_valid = 1; acc_ready = 1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            chk("t2_d1_wt_addr", o_wt[0], (n >= 2 && n <= 10) ? n - 2 : 0);
            chk("t2_d1_win_ready", o_wr[0], n == 10);
            chk("t2_d1_mac_en", o_en[0], n >= 3 && n <= 11);
            chk("t2_d1_mac_clr", o_clr[0], n == 3);
            chk("t2_d1_acc_valid", o_av[0], n == 12);
            chk("t2_d1_win_cnt", o_cnt[0], (n >= 13) ? 1 : 0);
            chk("t2_d2_wt_addr", o_wt[1], (n >= 2 && n <= 10) ? n - 2 : 0);
            chk("t2_d2_mac_en", o_en[1], n >= 4 && n <= 12);
            chk("t2_d2_mac_clr", o_clr[1], n == 4);
            chk("t2_d2_acc_valid", o_av[1], n == 13);
            chk("t2_d2_frame_done", o_fd[1], n == 14);
            chk("t2_d2_busy", o_busy[1], n >= 1 && n <= 13);
            @(posedge clk); #1;
            start = 0;
            if (n == 11) win_valid = 0;
        end

        // win_valid stall: dut1 sits in WAIT_WIN
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall_wv_wt_addr", o_wt[0], 0);
            chk("stall_wv_mac_en", o_en[0], 0);
            chk("stall_wv_busy", o_busy[0], 1);
        end
        win_valid = 1; acc_ready = 0;
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (o_av[0]) found = 1;
        end
        chk("wait_acc_valid", found, 1);
        // acc_ready stall: acc_valid held, count frozen, no new ISSUE
        for (int n = 0; n < 4; n++) begin
            chk("stall_ar_acc_valid", o_av[0], 1);
            chk("stall_ar_win_cnt", o_cnt[0], 1);
            chk("stall_ar_wt_addr", o_wt[0], 0);
            @(negedge clk);
        end
        acc_ready = 1;
        @(posedge clk); #1 abort = 1;
        @(posedge clk); #1 abort = 0;

        // Full 3-window frame on dut1, with extra starts while busy
        cnt_on = 1;
        start = 1; win_valid = 1; acc_ready = 1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            start = (n == 6 || n == 26);
        end
        cnt_on = 0;
        chk("frame_win_ready", n_wr, 3);
        chk("frame_mac_en", n_en, 27);
        chk("frame_mac_clr", n_clr, 3);
        chk("frame_done_cnt", n_fd, 1);
        chk("frame_cnt_steps", seen.size(), 3);
        for (int i = 0; i < seen.size() && i < 3; i++) chk("frame_cnt_val", seen[i], i);
        repeat (20) @(posedge clk);
        #1;

        // Abort at tap 4 of the first window (RD_LAT=2 instance among them)
        start = 1;
        @(posedge clk); #1 start = 0;
        wait_tap(1, 4, 0, "wait_tap4_first");
        abort = 1;
        @(posedge clk); #1 abort = 0; win_valid = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk("abort1_d2_mac_en", o_en[1], 0);
            chk("abort1_d2_acc_valid", o_av[1], 0);
            chk("abort1_d2_busy", o_busy[1], 0);
            chk("abort1_d1_mac_en", o_en[0], 0);
        end
        // Restart; let dut1 reach its second window then abort at tap 4
        @(posedge clk); #1 start = 1; win_valid = 1;
        @(posedge clk); #1 start = 0;
        wait_tap(0, 4, 1, "wait_tap4_second");
        abort = 1;
        @(posedge clk); #1 abort = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("abort2_d1_win_cnt_hold", o_cnt[0], 1);
            chk("abort2_d1_mac_en", o_en[0], 0);
            chk("abort2_d1_acc_valid", o_av[0], 0);
        end
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("restart_d1_win_cnt", o_cnt[0], 0);
        chk("restart_d2_busy", o_busy[1], 1);
        repeat (30) @(posedge clk);

        // Random phase with an async reset in the middle
        for (int n = 0; n < 2500; n++) begin
            @(posedge clk); #1;
            start     = ($urandom_range(0, 5) == 0);
            abort     = ($urandom_range(0, 299) == 0);
            win_valid = ($urandom_range(0, 1) == 1);
            acc_ready = ($urandom_range(0, 2) != 0);
            if (n == 1200) begin
                rst_n = 1'b0;
                #1 chk_zero("mid_reset");
                @(posedge clk); #1 rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
